// File: rtl/ctrl_pipe.sv
// Control-word pipeline: decodes the packed ID-stage control word and carries the
// sanitised fields through ID/EX, EX/MEM and MEM/WB with stall/flush bubbles and halt.
module ctrl_pipe #(
  parameter int CTRL_W     = 20,
  parameter int REG_ADDR_W = 5,
  parameter int GPR_LINK   = 31
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [CTRL_W-1:0]     i_ctrl_word,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_halt,
  output logic                  o_id_next_pc_src,
  output logic [1:0]            o_id_jmp_ctrl,
  output logic                  o_ex_alu_src_a,
  output logic [2:0]            o_ex_alu_src_b,
  output logic [2:0]            o_ex_alu_op,
  output logic                  o_ex_mem_read,
  output logic                  o_ex_wr_en,
  output logic [REG_ADDR_W-1:0] o_ex_wr_addr,
  output logic [2:0]            o_mem_rd_src,
  output logic [1:0]            o_mem_wr_src,
  output logic                  o_mem_write,
  output logic                  o_mem_wr_en,
  output logic [REG_ADDR_W-1:0] o_mem_wr_addr,
  output logic                  o_mem_to_reg,
  output logic                  o_wb_wr_en,
  output logic [REG_ADDR_W-1:0] o_wb_wr_addr,
  output logic                  o_wb_mem_to_reg
);

  typedef struct packed {
    logic                  alu_src_a;
    logic [2:0]            alu_src_b;
    logic [2:0]            alu_op;
    logic                  mem_read;
    logic [2:0]            mem_rd_src;
    logic [1:0]            mem_wr_src;
    logic                  mem_write;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic                  mem_to_reg;
  } id_ex_t;

  typedef struct packed {
    logic [2:0]            mem_rd_src;
    logic [1:0]            mem_wr_src;
    logic                  mem_write;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic                  mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic                  mem_to_reg;
  } mem_wb_t;

  id_ex_t  dec;
  id_ex_t  id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  logic [1:0]            reg_dst;
  logic                  wb_en;
  logic                  raw_m2r;
  logic [REG_ADDR_W-1:0] dst_addr;

  assign o_id_next_pc_src = i_ctrl_word[19];
  assign o_id_jmp_ctrl    = i_ctrl_word[18:17];

  // Don't-care fields are zeroed here so downstream stages never see stale bits.
  always_comb begin
    dec      = '0;
    reg_dst  = i_ctrl_word[16:15];
    wb_en    = i_ctrl_word[1];
    raw_m2r  = i_ctrl_word[0];
    dst_addr = '0;
    case (reg_dst)
      2'b00:   dst_addr = i_rt;
      2'b01:   dst_addr = i_rd;
      2'b10:   dst_addr = REG_ADDR_W'(GPR_LINK);
      default: dst_addr = '0;
    endcase
    if (!wb_en) dst_addr = '0;

    dec.alu_src_a  = i_ctrl_word[14];
    dec.alu_src_b  = i_ctrl_word[13:11];
    dec.alu_op     = i_ctrl_word[10:8];
    dec.mem_read   = wb_en & ~raw_m2r;
    dec.mem_rd_src = dec.mem_read ? i_ctrl_word[7:5] : 3'b000;
    dec.mem_write  = i_ctrl_word[2];
    dec.mem_wr_src = i_ctrl_word[2] ? i_ctrl_word[4:3] : 2'b00;
    dec.mem_to_reg = wb_en & raw_m2r;
    dec.wr_addr    = dst_addr;
    // r0 is never a write target, so it can never be forwarded either.
    dec.wr_en      = wb_en && (reg_dst != 2'b11) && (dst_addr != '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (!i_halt) begin
      id_ex              <= (i_stall | i_flush) ? '0 : dec;
      ex_mem.mem_rd_src  <= id_ex.mem_rd_src;
      ex_mem.mem_wr_src  <= id_ex.mem_wr_src;
      ex_mem.mem_write   <= id_ex.mem_write;
      ex_mem.wr_en       <= id_ex.wr_en;
      ex_mem.wr_addr     <= id_ex.wr_addr;
      ex_mem.mem_to_reg  <= id_ex.mem_to_reg;
      mem_wb.wr_en       <= ex_mem.wr_en;
      mem_wb.wr_addr     <= ex_mem.wr_addr;
      mem_wb.mem_to_reg  <= ex_mem.mem_to_reg;
    end
  end

  assign o_ex_alu_src_a  = id_ex.alu_src_a;
  assign o_ex_alu_src_b  = id_ex.alu_src_b;
  assign o_ex_alu_op     = id_ex.alu_op;
  assign o_ex_mem_read   = id_ex.mem_read;
  assign o_ex_wr_en      = id_ex.wr_en;
  assign o_ex_wr_addr    = id_ex.wr_addr;
  assign o_mem_rd_src    = ex_mem.mem_rd_src;
  assign o_mem_wr_src    = ex_mem.mem_wr_src;
  assign o_mem_write     = ex_mem.mem_write;
  assign o_mem_wr_en     = ex_mem.wr_en;
  assign o_mem_wr_addr   = ex_mem.wr_addr;
  assign o_mem_to_reg    = ex_mem.mem_to_reg;
  assign o_wb_wr_en      = mem_wb.wr_en;
  assign o_wb_wr_addr    = mem_wb.wr_addr;
  assign o_wb_mem_to_reg = mem_wb.mem_to_reg;

endmodule
